// File: rtl/uart_mmio_if.sv
// Bus-side port bundle of uart_mmio: decoder select, word offset, write data/strobes
// and the registered read data returned one cycle later.
interface uart_mmio_if;
    logic        bus_sel;
    logic [1:0]  bus_addr;
    logic [31:0] bus_data_w;
    logic [3:0]  bus_mask_w;
    logic [31:0] bus_data_r;

    modport master (output bus_sel, bus_addr, bus_data_w, bus_mask_w, input bus_data_r);
    modport slave  (input bus_sel, bus_addr, bus_data_w, bus_mask_w, output bus_data_r);
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TX byte FIFO plus shifter, registered zero-wait-state reads.
// Define UART_RX_EN to build the receiver, its flags and the RXDATA register.
module uart_mmio #(
    parameter int          FIFO_LOG2 = 3,
    parameter logic [15:0] DIV_RESET = 16'd867
) (
    input  logic       clock,
    input  logic       reset,
    uart_mmio_if.slave bus,
    output logic       uart_tx,
    input  logic       uart_rx
);
    localparam int                   DEPTH      = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0]   FULL_COUNT = (FIFO_LOG2 + 1)'(DEPTH);
    localparam logic [FIFO_LOG2-1:0] PTR_ONE    = FIFO_LOG2'(1);
    localparam logic [FIFO_LOG2:0]   CNT_ONE    = (FIFO_LOG2 + 1)'(1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic        wr_en, wr_tx, wr_status, wr_div;
    logic [15:0] divisor;
    logic        tx_overflow;
    logic        rx_valid, rx_overrun, rx_frame_err;
    logic [7:0]  rx_byte;

    logic [7:0]           fifo_mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
    logic [FIFO_LOG2:0]   fifo_cnt;
    logic                 fifo_full, fifo_empty, push_ok, tx_pop;

    tx_state_t   tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n;
    logic [2:0]  tx_idx, tx_idx_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic        tx_line_n, tx_idle;
    logic [31:0] rd_val;
    logic [18:0] unused_bus;

    assign wr_en     = bus.bus_sel & bus.bus_mask_w[0];
    assign wr_tx     = wr_en && (bus.bus_addr == 2'd0);
    assign wr_status = wr_en && (bus.bus_addr == 2'd1);
    assign wr_div    = wr_en && (bus.bus_addr == 2'd3);

    assign fifo_full  = (fifo_cnt == FULL_COUNT);
    assign fifo_empty = (fifo_cnt == '0);
    // Fullness is judged on the pre-edge count, so a push is dropped even if the shifter pops now.
    assign push_ok    = wr_tx & ~fifo_full;
    assign tx_idle    = fifo_empty && (tx_state == TX_IDLE);
    assign unused_bus = {bus.bus_data_w[31:16], bus.bus_mask_w[3:1]};

    always_ff @(posedge clock) begin
        if (push_ok) fifo_mem[wr_ptr] <= bus.bus_data_w[7:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (tx_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push_ok && !tx_pop)      fifo_cnt <= fifo_cnt + CNT_ONE;
            else if (!push_ok && tx_pop) fifo_cnt <= fifo_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            divisor     <= DIV_RESET;
            tx_overflow <= 1'b0;
        end else begin
            if (wr_div) divisor <= bus.bus_data_w[15:0];
            if (wr_tx && fifo_full)                    tx_overflow <= 1'b1;
            else if (wr_status && bus.bus_data_w[4])   tx_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_shift <= tx_shift_n;
            uart_tx  <= tx_line_n;
        end
    end

    // The bit counter reloads from the live divisor at every boundary, so rate changes
    // take effect from the next bit; the line level is registered to stay glitch-free.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt - 16'd1;
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        tx_line_n  = uart_tx;
        tx_pop     = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                tx_cnt_n  = tx_cnt;
                tx_line_n = 1'b1;
                if (!fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_n = TX_START;
                    tx_shift_n = fifo_mem[rd_ptr];
                    tx_cnt_n   = divisor;
                    tx_line_n  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt == '0) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = divisor;
                    tx_idx_n   = '0;
                    tx_line_n  = tx_shift[0];
                end
            end
            TX_DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_n   = divisor;
                    tx_shift_n = tx_shift >> 1;
                    if (tx_idx == 3'd7) begin
                        tx_state_n = TX_STOP;
                        tx_line_n  = 1'b1;
                    end else begin
                        tx_idx_n  = tx_idx + 3'd1;
                        tx_line_n = tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt == '0) begin
                    tx_cnt_n = divisor;
                    if (!fifo_empty) begin
                        tx_pop     = 1'b1;
                        tx_state_n = TX_START;
                        tx_shift_n = fifo_mem[rd_ptr];
                        tx_line_n  = 1'b0;
                    end else begin
                        tx_state_n = TX_IDLE;
                        tx_line_n  = 1'b1;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

`ifdef UART_RX_EN
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t   rx_state, rx_state_n;
    logic        rx_sync1, rx_sync2, rx_prev;
    logic [15:0] rx_cnt, rx_cnt_n;
    logic [2:0]  rx_idx, rx_idx_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        rx_good, rx_bad, rx_pop;

    assign rx_pop = wr_en && (bus.bus_addr == 2'd2);

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            rx_sync1 <= uart_rx;
            rx_sync2 <= rx_sync1;
            rx_prev  <= rx_sync2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_shift <= rx_shift_n;
        end
    end

    // The start bit is checked half a period in, so every later sample lands mid-bit.
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt - 16'd1;
        rx_idx_n   = rx_idx;
        rx_shift_n = rx_shift;
        rx_good    = 1'b0;
        rx_bad     = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = rx_cnt;
                if (rx_prev && !rx_sync2) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = divisor >> 1;
                end
            end
            RX_START: begin
                if (rx_cnt == '0) begin
                    rx_cnt_n = divisor;
                    rx_idx_n = '0;
                    rx_state_n = rx_sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == '0) begin
                    rx_cnt_n   = divisor;
                    rx_shift_n = {rx_sync2, rx_shift[7:1]};
                    if (rx_idx == 3'd7) rx_state_n = RX_STOP;
                    else                rx_idx_n   = rx_idx + 3'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == '0) begin
                    rx_state_n = RX_IDLE;
                    rx_good    = rx_sync2;
                    rx_bad     = ~rx_sync2;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // A pop on the same edge as a new byte frees the holder, so the load wins without overrun.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_valid     <= 1'b0;
            rx_byte      <= '0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (rx_good && (!rx_valid || rx_pop)) begin
                rx_valid <= 1'b1;
                rx_byte  <= rx_shift;
            end else if (rx_pop) begin
                rx_valid <= 1'b0;
            end
            if (rx_good && rx_valid && !rx_pop)         rx_overrun <= 1'b1;
            else if (wr_status && bus.bus_data_w[3])    rx_overrun <= 1'b0;
            if (rx_bad)                                 rx_frame_err <= 1'b1;
            else if (wr_status && bus.bus_data_w[5])    rx_frame_err <= 1'b0;
        end
    end
`else
    logic unused_rx;
    assign unused_rx    = uart_rx;
    assign rx_valid     = 1'b0;
    assign rx_overrun   = 1'b0;
    assign rx_frame_err = 1'b0;
    assign rx_byte      = '0;
`endif

    always_comb begin
        rd_val = '0;
        unique case (bus.bus_addr)
            2'd1: begin
                rd_val[0]    = fifo_full;
                rd_val[1]    = tx_idle;
                rd_val[2]    = rx_valid;
                rd_val[3]    = rx_overrun;
                rd_val[4]    = tx_overflow;
                rd_val[5]    = rx_frame_err;
                rd_val[15:8] = 8'(fifo_cnt);
            end
            2'd2:    rd_val[8:0]  = {rx_valid, rx_byte};
            2'd3:    rd_val[15:0] = divisor;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) bus.bus_data_r <= '0;
        else       bus.bus_data_r <= bus.bus_sel ? rd_val : 32'd0;
    end
endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: register map, TX framing and FIFO, reset behaviour,
// and the receiver when UART_RX_EN is defined (its absence otherwise).
module tb_uart_mmio;
    logic clock = 1'b0;
    logic reset;
    logic uart_tx;
    logic uart_rx;
    int   errors = 0;
    int   checks = 0;

    logic       m_valid, m_overrun, m_ferr;
    logic [7:0] m_byte;

    uart_mmio_if bus ();

    uart_mmio #(.FIFO_LOG2(3), .DIV_RESET(16'd867)) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus),
        .uart_tx(uart_tx),
        .uart_rx(uart_rx)
    );

    always #5 clock = ~clock;

    // Serial frame of a byte: start 0, data LSB first, stop 1.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return b[i-1];
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output logic [31:0] rd);
        bus.bus_sel = 1'b1; bus.bus_addr = a; bus.bus_data_w = d; bus.bus_mask_w = 4'hF;
        @(posedge clock); #1;
        rd = bus.bus_data_r;
        bus.bus_sel = 1'b0; bus.bus_mask_w = 4'h0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] rd);
        bus.bus_sel = 1'b1; bus.bus_addr = a; bus.bus_mask_w = 4'h0;
        @(posedge clock); #1;
        rd = bus.bus_data_r;
        bus.bus_sel = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop_ok, input int d);
        for (int i = 0; i < 10; i++) begin
            uart_rx = (i == 9) ? stop_ok : frame_bit(b, i);
            repeat (d + 1) begin @(posedge clock); #1; end
        end
        uart_rx = 1'b1;
        repeat (4) begin @(posedge clock); #1; end
        if (!stop_ok)     m_ferr = 1'b1;
        else if (m_valid) m_overrun = 1'b1;
        else begin m_valid = 1'b1; m_byte = b; end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] exp_regs [4];
        exp_regs = '{32'd0, 32'h2, 32'd0, 32'd867};
        reset = 1'b1; uart_rx = 1'b1;
        bus.bus_sel = 1'b0; bus.bus_addr = 2'd0; bus.bus_data_w = '0; bus.bus_mask_w = '0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx observed=%b required=1", uart_tx); end
        checks++; if (bus.bus_data_r !== 32'd0) begin errors++; $display("[TB] FAIL reset_rdata observed=%h required=0", bus.bus_data_r); end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_read(2'(i), rd);
            checks++;
            if (rd !== exp_regs[i]) begin errors++; $display("[TB] FAIL reset_reg%0d observed=%h required=%h", i, rd, exp_regs[i]); end
        end
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx_idle observed=%b required=1", uart_tx); end
    endtask

    task automatic test_registers();
        logic [31:0] rd, v;
        logic [15:0] prev;
        prev = 16'd867;
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            bus_write(2'd3, v, rd);
            checks++;
            if (rd !== {16'd0, prev}) begin errors++; $display("[TB] FAIL div_collision observed=%h required=%h", rd, {16'd0, prev}); end
            prev = v[15:0];
            bus_read(2'd3, rd);
            checks++;
            if (rd !== {16'd0, prev}) begin errors++; $display("[TB] FAIL div_readback observed=%h required=%h", rd, {16'd0, prev}); end
        end
        bus.bus_sel = 1'b0; bus.bus_addr = 2'd3;
        @(posedge clock); #1;
        checks++; if (bus.bus_data_r !== 32'd0) begin errors++; $display("[TB] FAIL unselected_read observed=%h required=0", bus.bus_data_r); end
        bus_read(2'd0, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("[TB] FAIL txdata_read observed=%h required=0", rd); end
    endtask

    task automatic test_single_frame();
        logic [31:0] rd;
        logic [7:0]  b;
        logic        s, first, same, obs;
        int          d, per;
        for (int c = 0; c < 2; c++) begin
            d   = (c == 0) ? 3 : int'($urandom_range(1, 6));
            b   = (c == 0) ? 8'hA5 : 8'($urandom);
            per = d + 1;
            bus_write(2'd3, 32'(d), rd);
            bus_write(2'd0, {24'd0, b}, rd);
            checks++; if (uart_tx !== 1'b1) begin errors++; $display("[TB] FAIL tx_before_start observed=%b required=1", uart_tx); end
            first = 1'b1; same = 1'b1;
            for (int k = 0; k < 10 * per; k++) begin
                if (k == 4 * per) begin bus.bus_sel = 1'b1; bus.bus_addr = 2'd1; end
                @(posedge clock); #1;
                s = uart_tx;
                if (k == 4 * per) begin
                    checks++;
                    if (bus.bus_data_r !== 32'd0) begin errors++; $display("[TB] FAIL status_busy observed=%h required=0", bus.bus_data_r); end
                    bus.bus_sel = 1'b0;
                end
                if (k % per == 0) begin first = s; same = 1'b1; end
                else if (s !== first) same = 1'b0;
                if (k % per == per - 1) begin
                    obs = same ? first : 1'bx;
                    checks++;
                    if (obs !== frame_bit(b, k / per)) begin
                        errors++;
                        $display("[TB] FAIL tx_bit byte=%h bit=%0d observed=%b required=%b", b, k / per, obs, frame_bit(b, k / per));
                    end
                end
            end
            bus_read(2'd1, rd);
            checks++; if (rd !== 32'd0) begin errors++; $display("[TB] FAIL status_in_stop observed=%h required=0", rd); end
            bus_read(2'd1, rd);
            checks++; if (rd !== 32'h2) begin errors++; $display("[TB] FAIL status_idle observed=%h required=2", rd); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [7:0]  bytes [10];
        logic        s, first, same, obs, expb;
        int          per, flen, lows;
        per  = 4;
        flen = 10 * per;
        for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom);
        bus_write(2'd3, 32'd3, rd);
        bus_write(2'd0, {24'd0, bytes[0]}, rd);
        first = 1'b1; same = 1'b1;
        for (int k = 0; k < 9 * flen; k++) begin
            if (k < 9) begin
                bus.bus_sel = 1'b1; bus.bus_addr = 2'd0; bus.bus_data_w = {24'd0, bytes[k+1]}; bus.bus_mask_w = 4'hF;
            end else if (k == 9 || k == 11) begin
                bus.bus_sel = 1'b1; bus.bus_addr = 2'd1; bus.bus_mask_w = 4'h0;
            end else if (k == 10) begin
                bus.bus_sel = 1'b1; bus.bus_addr = 2'd1; bus.bus_data_w = 32'h10; bus.bus_mask_w = 4'hF;
            end
            @(posedge clock); #1;
            s = uart_tx;
            if (k == 9) begin
                checks++;
                if (bus.bus_data_r !== 32'h0811) begin errors++; $display("[TB] FAIL status_full_ovf observed=%h required=00000811", bus.bus_data_r); end
            end
            if (k == 11) begin
                checks++;
                if (bus.bus_data_r !== 32'h0801) begin errors++; $display("[TB] FAIL status_ovf_clear observed=%h required=00000801", bus.bus_data_r); end
            end
            bus.bus_sel = 1'b0; bus.bus_mask_w = 4'h0;
            if (k % per == 0) begin first = s; same = 1'b1; end
            else if (s !== first) same = 1'b0;
            if (k % per == per - 1) begin
                obs  = same ? first : 1'bx;
                expb = frame_bit(bytes[k / flen], (k / per) % 10);
                checks++;
                if (obs !== expb) begin
                    errors++;
                    $display("[TB] FAIL b2b_bit frame=%0d bit=%0d observed=%b required=%b", k / flen, (k / per) % 10, obs, expb);
                end
            end
        end
        @(posedge clock); #1;
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'h2) begin errors++; $display("[TB] FAIL b2b_status_end observed=%h required=2", rd); end
        lows = 0;
        repeat (60) begin @(posedge clock); #1; if (uart_tx !== 1'b1) lows++; end
        checks++; if (lows !== 0) begin errors++; $display("[TB] FAIL dropped_byte_sent low_cycles=%0d required=0", lows); end
    endtask

`ifdef UART_RX_EN
    task automatic test_rx_basic();
        logic [31:0] rd;
        m_valid = 1'b0; m_overrun = 1'b0; m_ferr = 1'b0; m_byte = 8'd0;
        bus_write(2'd3, 32'd7, rd);
        rx_send(8'h3C, 1'b1, 7);
        bus_read(2'd2, rd);
        checks++; if (rd !== {23'd0, m_valid, m_byte}) begin errors++; $display("[TB] FAIL rx_first observed=%h required=%h", rd, {23'd0, m_valid, m_byte}); end
        rx_send(8'h55, 1'b1, 7);
        bus_read(2'd2, rd);
        checks++; if (rd !== 32'h13C) begin errors++; $display("[TB] FAIL rx_kept observed=%h required=0000013c", rd); end
        bus_read(2'd1, rd);
        checks++; if (rd !== {26'd0, m_ferr, 1'b0, m_overrun, m_valid, 2'b10}) begin errors++; $display("[TB] FAIL rx_overrun_status observed=%h required=%h", rd, {26'd0, m_ferr, 1'b0, m_overrun, m_valid, 2'b10}); end
        bus_write(2'd2, 32'd0, rd);
        bus_write(2'd1, 32'h28, rd);
        m_valid = 1'b0; m_overrun = 1'b0; m_ferr = 1'b0;
        bus_read(2'd2, rd);
        checks++; if (rd !== {23'd0, 1'b0, m_byte}) begin errors++; $display("[TB] FAIL rx_pop observed=%h required=%h", rd, {23'd0, 1'b0, m_byte}); end
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'h2) begin errors++; $display("[TB] FAIL rx_clear_status observed=%h required=2", rd); end
    endtask

    task automatic test_rx_errors();
        logic [31:0] rd;
        rx_send(8'h41, 1'b0, 7);
        bus_read(2'd1, rd);
        checks++; if (rd !== {26'd0, m_ferr, 1'b0, m_overrun, m_valid, 2'b10}) begin errors++; $display("[TB] FAIL rx_frame_err observed=%h required=%h", rd, {26'd0, m_ferr, 1'b0, m_overrun, m_valid, 2'b10}); end
        bus_write(2'd1, 32'h28, rd);
        m_ferr = 1'b0;
        bus_write(2'd3, 32'd15, rd);
        uart_rx = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        uart_rx = 1'b1;
        repeat (40) begin @(posedge clock); #1; end
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'h2) begin errors++; $display("[TB] FAIL rx_glitch_status observed=%h required=2", rd); end
        bus_read(2'd2, rd);
        checks++; if (rd !== {23'd0, 1'b0, m_byte}) begin errors++; $display("[TB] FAIL rx_glitch_data observed=%h required=%h", rd, {23'd0, 1'b0, m_byte}); end
    endtask

    task automatic test_rx_random();
        logic [31:0] rd;
        logic [7:0]  b;
        int          d;
        d = int'($urandom_range(4, 12));
        bus_write(2'd3, 32'(d), rd);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            rx_send(b, 1'b1, d);
            bus_read(2'd2, rd);
            checks++; if (rd !== {23'd0, m_valid, m_byte}) begin errors++; $display("[TB] FAIL rx_random observed=%h required=%h", rd, {23'd0, m_valid, m_byte}); end
            bus_write(2'd2, 32'd0, rd);
            m_valid = 1'b0;
        end
    endtask
`else
    task automatic test_rx_disabled();
        logic [31:0] rd;
        uart_rx = 1'b0;
        repeat (20) begin @(posedge clock); #1; end
        uart_rx = 1'b1;
        repeat (20) begin @(posedge clock); #1; end
        bus_write(2'd2, 32'hFFFF_FFFF, rd);
        bus_read(2'd2, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("[TB] FAIL rxdata_disabled observed=%h required=0", rd); end
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'h2) begin errors++; $display("[TB] FAIL status_rx_disabled observed=%h required=2", rd); end
    endtask
`endif

    task automatic test_reset_mid_frame();
        logic [31:0] rd;
        int          lows;
        bus_write(2'd3, 32'd3, rd);
        for (int i = 0; i < 4; i++) bus_write(2'd0, $urandom, rd);
        repeat (6) begin @(posedge clock); #1; end
        reset = 1'b1;
        @(posedge clock); #1;
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("[TB] FAIL midframe_reset_tx observed=%b required=1", uart_tx); end
        checks++; if (bus.bus_data_r !== 32'd0) begin errors++; $display("[TB] FAIL midframe_reset_rdata observed=%h required=0", bus.bus_data_r); end
        reset = 1'b0;
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'h2) begin errors++; $display("[TB] FAIL midframe_status observed=%h required=2", rd); end
        bus_read(2'd3, rd);
        checks++; if (rd !== 32'd867) begin errors++; $display("[TB] FAIL midframe_divisor observed=%0d required=867", rd); end
        lows = 0;
        repeat (100) begin @(posedge clock); #1; if (uart_tx !== 1'b1) lows++; end
        checks++; if (lows !== 0) begin errors++; $display("[TB] FAIL midframe_no_frames low_cycles=%0d required=0", lows); end
    endtask

    initial begin
        test_reset();
        test_registers();
        test_single_frame();
        test_back_to_back();
`ifdef UART_RX_EN
        test_rx_basic();
        test_rx_errors();
        test_rx_random();
`else
        test_rx_disabled();
`endif
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped 8N1 UART peripheral on the CPU data/instruction bus, downstream of the address decoder. It consumes the CPU's combinational bus address, write data and write mask. It returns registered read data one cycle later, matching the zero-wait-state synchronous-read contract the CPU expects of every bus slave. The transmitter is fed through a byte FIFO; the receiver (optional) delivers into a single holding register.

## Interface
- FIFO_LOG2, default 3: TX FIFO depth = 2**FIFO_LOG2 bytes.
- DIV_RESET, default 16'd867: reset value of DIVISOR; bit period = DIVISOR+1 clocks (115200 baud at 100 MHz).
- clock  in  1  sole clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- bus_sel  in  1  decoder select; this block owns the current bus_addr.
- bus_addr  in  2  word offset within block (CPU bus_addr[1:0]).
- bus_data_w  in  32  write data.
- bus_mask_w  in  4  byte write strobes; a write occurs when bus_sel & bus_mask_w[0].
- bus_data_r  out  32  registered read data.
- uart_tx  out  1  serial out, idle high.
- uart_rx  in  1  serial in, asynchronous.

## Operation
- Register map (word offset):
  - 0 TXDATA: write pushes data_w[7:0]; if FIFO full, byte dropped and tx_overflow set. Reads 0.
  - 1 STATUS: read [0] tx_full, [1] tx_idle (FIFO empty and shifter idle), [2] rx_valid, [3] rx_overrun, [4] tx_overflow, [5] rx_frame_err, [15:8] FIFO count, rest 0. Write 1 to bits 3/4/5 clears that sticky flag.
  - 2 RXDATA: read {23'b0, rx_valid, rx_byte}. Non-destructive; any write pops (clears rx_valid).
  - 3 DIVISOR: read/write [15:0]; upper bits read 0.
- Reads never have side effects, since the CPU drives bus_addr every cycle including fetches.
- TX: states IDLE, START, DATA(0..7, LSB first), STOP. In IDLE with FIFO non-empty: pop, go START. After STOP: if FIFO non-empty, go straight to START, with no gap.
- Each bit lasts DIVISOR+1 clocks. The bit counter reloads from DIVISOR at every bit boundary, so a mid-frame DIVISOR write applies from the next bit.
- RX: 2-flop synchroniser. States IDLE, START, DATA, STOP.
  - IDLE to START on a synchronised falling edge.
  - Sample at half-period (DIVISOR>>1). Start bit high at sample: abort to IDLE.
  - Data bits sampled at mid-bit, every DIVISOR+1 clocks.
  - Stop bit low: set rx_frame_err, discard byte.
  - Good byte with rx_valid clear: load rx_byte, set rx_valid.
  - Good byte with rx_valid set: set rx_overrun, drop new byte, keep old one.
- Arithmetic: FIFO pointers FIFO_LOG2 bits wrapping; count FIFO_LOG2+1 bits, zero-extended into STATUS[15:8].

## Timing
- Reset values:
  - bus_data_r = 0 and uart_tx = 1.
  - FIFO empty; all flags 0; rx_valid 0; DIVISOR = DIV_RESET.
  - TX and RX state IDLE.
- Reset mid-frame: uart_tx is high after the reset edge, and the frame is abandoned.
- Read latency 1: bus_data_r after edge N reflects register state before edge N for the offset presented in cycle N. It is 0 if bus_sel was low in cycle N.
- Simultaneous read and write to the same offset: read returns the pre-write value.
- Writes commit at the edge ending the cycle.
- Push while full uses pre-edge count and is dropped even if the shifter pops on the same edge. Push and pop on the same edge when not full: count unchanged.
- TX start latency: a push at edge N into an empty FIFO with idle shifter pops at edge N+1. uart_tx is low from edge N+1 for DIVISOR+1 clocks.
- A frame occupies 10*(DIVISOR+1) clocks.
- RX: byte visible (rx_valid) 1 clock after the stop-bit sample. A pop and a new-byte load on the same edge: the load wins, with no overrun.
- Flag set and software clear on the same edge: set wins.

## Configuration
- UART_RX_EN defined: receiver, RX flags and RXDATA implemented.
- UART_RX_EN undefined:
  - uart_rx ignored; no RX logic.
  - STATUS[2], [3], [5] and RXDATA read 0; RXDATA writes and STATUS bit 3/5 clears are no-ops.

## Test plan
- Reset, then read offsets 0-3 -> 0, 0x00000002, 0, 867; uart_tx = 1 throughout.
- DIVISOR = 3, push 0xA5 -> uart_tx low 4 clocks starting 1 clock after push edge, then 1,0,1,0,0,1,0,1 (4 clocks each), then high 4 clocks; STATUS[1] returns to 1 after the stop bit.
- DIVISOR = 3, 9 back-to-back pushes with FIFO_LOG2 = 3 -> first pops immediately, 8 queue, none lost; 10th push while full -> dropped, STATUS[4] = 1; write 0x10 to STATUS clears it.
- (UART_RX_EN) DIVISOR = 7, drive frame 0x3C on uart_rx -> RXDATA = 0x13C. Drive a second frame 0x55 without popping -> RXDATA still 0x13C, STATUS[3] = 1.
- (UART_RX_EN) Drive a 0x41 frame with the stop bit low -> rx_valid stays 0, STATUS[5] = 1. Drive a 3-clock low glitch with DIVISOR = 15 -> no byte, no flags.
- Assert reset mid-TX-frame with 3 bytes queued -> uart_tx = 1 next clock, STATUS = 0x00000002, no further frames.
